// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared constants, funct3 codes and FSM state type for the iterative multiplier
package mul_pkg;

    localparam int DATA_W = 64;
    localparam int MUL_W  = 2 * DATA_W;

    localparam logic [6:0] OPC_RV32M = 7'b0110011;
    localparam logic [6:0] OPC_RV64M = 7'b0111011;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_step_adder.sv
// rtl/mul_step_adder.sv - one shift-add step: acc_hi + mcand * mbits with carry out
module mul_step_adder #(
    parameter int DATA_W         = 64,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic [DATA_W-1:0]         acc_hi,
    input  logic [DATA_W-1:0]         mcand,
    input  logic [BITS_PER_CYCLE-1:0] mbits,
    output logic [DATA_W-1:0]         sum,
    output logic [BITS_PER_CYCLE-1:0] carry
);

    localparam int SUM_W = DATA_W + BITS_PER_CYCLE;

    logic [SUM_W-1:0] total;
    logic [SUM_W-1:0] mcand_ext;

    assign mcand_ext = {{BITS_PER_CYCLE{1'b0}}, mcand};

    // Accumulate shifted copies of the multiplicand for each set multiplier bit;
    // the wide sum cannot overflow since (2^W-1)*2^B < 2^(W+B).
    always_comb begin
        total = {{BITS_PER_CYCLE{1'b0}}, acc_hi};
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mbits[i]) begin
                total = total + (mcand_ext << i);
            end
        end
    end

    assign sum   = total[DATA_W-1:0];
    assign carry = total[SUM_W-1:DATA_W];

endmodule

// File: rtl/mul_iter_core.sv
// rtl/mul_iter_core.sv - multi-cycle unsigned shift-add multiplier with valid/ready and flush
module mul_iter_core #(
    parameter int DATA_W         = 64,
    parameter int BITS_PER_CYCLE = 2,
    parameter int ZERO_SKIP      = 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  MulValidIn,
    output logic                  MulReadyOut,
    input  logic [DATA_W-1:0]     Mulitiplicand,
    input  logic [DATA_W-1:0]     Mulitiplier,
    input  logic [6:0]            MulOpCodeIn,
    input  logic [2:0]            MulFunct3In,
    input  logic                  MulitiplicandSignIn,
    input  logic                  MulitiplierSignIn,
    input  logic                  FlushFlag,
    output logic [2*DATA_W-1:0]   Product,
    output logic                  ProductValid,
    input  logic                  ProductReady,
    output logic [6:0]            MulOpCodeToEx,
    output logic [2:0]            MulFunct3ToEx,
    output logic                  MulitiplicandHighestBit,
    output logic                  MulitiplierHighestBit,
    output logic                  MulBusy
);

    import mul_pkg::*;

    localparam int PROD_W = 2 * DATA_W;
    localparam int N      = DATA_W / BITS_PER_CYCLE;
    localparam int CNT_W  = $clog2(N + 1);

    mul_state_e          state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [PROD_W-1:0]   product_q, product_d;
    logic [6:0]          opcode_q, opcode_d;
    logic [2:0]          funct3_q, funct3_d;
    logic                mcand_sign_q, mcand_sign_d;
    logic                mplier_sign_q, mplier_sign_d;

    logic [DATA_W-1:0]           step_sum;
    logic [BITS_PER_CYCLE-1:0]   step_carry;
    logic [PROD_W+BITS_PER_CYCLE-1:0] acc_ext;
    logic [PROD_W-1:0]           acc_next;
    logic                        zero_op;

    mul_step_adder #(
        .DATA_W         (DATA_W),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .acc_hi (acc_q[PROD_W-1:DATA_W]),
        .mcand  (mcand_q),
        .mbits  (mplier_q[BITS_PER_CYCLE-1:0]),
        .sum    (step_sum),
        .carry  (step_carry)
    );

    // Shift {carry, sum, acc_lo} right so retired product bits drain into the low half.
    always_comb begin
        acc_ext  = {step_carry, step_sum, acc_q[DATA_W-1:0]};
        acc_next = acc_ext[PROD_W+BITS_PER_CYCLE-1:BITS_PER_CYCLE];
    end

    assign zero_op = (ZERO_SKIP != 0) && ((Mulitiplicand == '0) || (Mulitiplier == '0));

    // Next-state and datapath update; flush overrides accept, iteration and handoff.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        mcand_d       = mcand_q;
        mplier_d      = mplier_q;
        acc_d         = acc_q;
        product_d     = product_q;
        opcode_d      = opcode_q;
        funct3_d      = funct3_q;
        mcand_sign_d  = mcand_sign_q;
        mplier_sign_d = mplier_sign_q;

        if (FlushFlag) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (MulValidIn) begin
                        mcand_d       = Mulitiplicand;
                        mplier_d      = Mulitiplier;
                        opcode_d      = MulOpCodeIn;
                        funct3_d      = MulFunct3In;
                        mcand_sign_d  = MulitiplicandSignIn;
                        mplier_sign_d = MulitiplierSignIn;
                        acc_d         = '0;
                        if (zero_op) begin
                            product_d = '0;
                            count_d   = '0;
                            state_d   = DONE;
                        end else begin
                            count_d   = CNT_W'(N);
                            state_d   = BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc_d    = acc_next;
                    mplier_d = mplier_q >> BITS_PER_CYCLE;
                    count_d  = count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        product_d = acc_next;
                        state_d   = DONE;
                    end
                end
                DONE: begin
                    if (ProductReady) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q       <= IDLE;
            count_q       <= '0;
            mcand_q       <= '0;
            mplier_q      <= '0;
            acc_q         <= '0;
            product_q     <= '0;
            opcode_q      <= '0;
            funct3_q      <= '0;
            mcand_sign_q  <= 1'b0;
            mplier_sign_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            mcand_q       <= mcand_d;
            mplier_q      <= mplier_d;
            acc_q         <= acc_d;
            product_q     <= product_d;
            opcode_q      <= opcode_d;
            funct3_q      <= funct3_d;
            mcand_sign_q  <= mcand_sign_d;
            mplier_sign_q <= mplier_sign_d;
        end
    end

    assign MulReadyOut             = (state_q == IDLE);
    assign ProductValid            = (state_q == DONE);
    assign MulBusy                 = (state_q != IDLE);
    assign Product                 = product_q;
    assign MulOpCodeToEx           = opcode_q;
    assign MulFunct3ToEx           = funct3_q;
    assign MulitiplicandHighestBit = mcand_sign_q;
    assign MulitiplierHighestBit   = mplier_sign_q;

endmodule

// File: tb/tb_mul_iter_core.sv
// tb/tb_mul_iter_core.sv - directed self-checking bench for mul_iter_core
module tb_mul_iter_core;

    localparam int DW = 64;

    logic           Clk;
    logic           Rst;
    logic           MulValidIn;
    logic           MulReadyOut;
    logic [DW-1:0]  Mulitiplicand;
    logic [DW-1:0]  Mulitiplier;
    logic [6:0]     MulOpCodeIn;
    logic [2:0]     MulFunct3In;
    logic           MulitiplicandSignIn;
    logic           MulitiplierSignIn;
    logic           FlushFlag;
    logic [2*DW-1:0] Product;
    logic           ProductValid;
    logic           ProductReady;
    logic [6:0]     MulOpCodeToEx;
    logic [2:0]     MulFunct3ToEx;
    logic           MulitiplicandHighestBit;
    logic           MulitiplierHighestBit;
    logic           MulBusy;

    int checks;
    int errors;

    mul_iter_core dut (
        .Clk                     (Clk),
        .Rst                     (Rst),
        .MulValidIn              (MulValidIn),
        .MulReadyOut             (MulReadyOut),
        .Mulitiplicand           (Mulitiplicand),
        .Mulitiplier             (Mulitiplier),
        .MulOpCodeIn             (MulOpCodeIn),
        .MulFunct3In             (MulFunct3In),
        .MulitiplicandSignIn     (MulitiplicandSignIn),
        .MulitiplierSignIn       (MulitiplierSignIn),
        .FlushFlag               (FlushFlag),
        .Product                 (Product),
        .ProductValid            (ProductValid),
        .ProductReady            (ProductReady),
        .MulOpCodeToEx           (MulOpCodeToEx),
        .MulFunct3ToEx           (MulFunct3ToEx),
        .MulitiplicandHighestBit (MulitiplicandHighestBit),
        .MulitiplierHighestBit   (MulitiplierHighestBit),
        .MulBusy                 (MulBusy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Presents one request at a negedge; returns 1 ns after the edge that samples it.
    task automatic do_accept(input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [6:0] opc, input logic [2:0] f3,
                             input logic sa, input logic sb);
        @(negedge Clk);
        Mulitiplicand       = a;
        Mulitiplier         = b;
        MulOpCodeIn         = opc;
        MulFunct3In         = f3;
        MulitiplicandSignIn = sa;
        MulitiplierSignIn   = sb;
        MulValidIn          = 1'b1;
        @(posedge Clk);
        #1;
        MulValidIn          = 1'b0;
    endtask

    // Counts rising edges after the accept edge until ProductValid; -1 if never.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int k = 0; k < 100; k++) begin
            if (ProductValid === 1'b1) begin
                lat = k;
                break;
            end
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic take_product();
        @(negedge Clk);
        ProductReady = 1'b1;
        @(posedge Clk);
        #1;
        ProductReady = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        #12;
        checks++;
        if (MulReadyOut !== 1'b1 || ProductValid !== 1'b0 || MulBusy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b valid=%b busy=%b, want 1 0 0", MulReadyOut, ProductValid, MulBusy);
        end
        checks++;
        if (Product !== '0 || MulOpCodeToEx !== 7'd0 || MulFunct3ToEx !== 3'd0 ||
            MulitiplicandHighestBit !== 1'b0 || MulitiplierHighestBit !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: product=%h opc=%b f3=%b signs=%b%b, want all zero",
                     Product, MulOpCodeToEx, MulFunct3ToEx, MulitiplicandHighestBit, MulitiplierHighestBit);
        end
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        do_accept(64'd3, 64'd5, 7'b0110011, 3'b001, 1'b1, 1'b0);
        checks++;
        if (MulBusy !== 1'b1 || MulReadyOut !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: busy=%b ready=%b, want 1 0", MulBusy, MulReadyOut);
        end
        wait_valid(lat);
        checks++;
        if (lat !== 32) begin
            errors++;
            $display("FAIL basic_latency: got %0d, want 32", lat);
        end
        checks++;
        if (Product !== 128'd15) begin
            errors++;
            $display("FAIL basic_product: got %0d, want 15", Product);
        end
        checks++;
        if (MulOpCodeToEx !== 7'b0110011 || MulFunct3ToEx !== 3'b001 ||
            MulitiplicandHighestBit !== 1'b1 || MulitiplierHighestBit !== 1'b0) begin
            errors++;
            $display("FAIL basic_sideband: opc=%b f3=%b signs=%b%b, want 0110011 001 10",
                     MulOpCodeToEx, MulFunct3ToEx, MulitiplicandHighestBit, MulitiplierHighestBit);
        end
        take_product();
        checks++;
        if (ProductValid !== 1'b0 || MulReadyOut !== 1'b1 || Product !== 128'd15) begin
            errors++;
            $display("FAIL basic_handoff: valid=%b ready=%b product=%0d, want 0 1 15", ProductValid, MulReadyOut, Product);
        end
    endtask

    task automatic test_max();
        int lat;
        do_accept({DW{1'b1}}, {DW{1'b1}}, 7'b0111011, 3'b011, 1'b0, 1'b0);
        wait_valid(lat);
        checks++;
        if (lat !== 32 || Product !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001) begin
            errors++;
            $display("FAIL max_product: lat=%0d product=%h, want 32 fffffffffffffffe0000000000000001", lat, Product);
        end
        take_product();
    endtask

    task automatic test_zero_skip();
        int lat;
        do_accept(64'd0, 64'hDEAD_BEEF, 7'b0110011, 3'b000, 1'b0, 1'b0);
        wait_valid(lat);
        checks++;
        if (lat !== 0 || Product !== '0) begin
            errors++;
            $display("FAIL zero_skip: lat=%0d product=%h, want 0 0", lat, Product);
        end
        @(negedge Clk);
        Mulitiplicand = 64'd5;
        Mulitiplier   = 64'd5;
        MulValidIn    = 1'b1;
        checks++;
        if (MulReadyOut !== 1'b0) begin
            errors++;
            $display("FAIL zero_done_ready: got %b, want 0", MulReadyOut);
        end
        @(posedge Clk);
        #1;
        MulValidIn = 1'b0;
        checks++;
        if (ProductValid !== 1'b1 || Product !== '0) begin
            errors++;
            $display("FAIL zero_done_hold: valid=%b product=%h, want 1 0", ProductValid, Product);
        end
        take_product();
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (MulBusy !== 1'b0 || ProductValid !== 1'b0) begin
            errors++;
            $display("FAIL zero_no_accept: busy=%b valid=%b, want 0 0", MulBusy, ProductValid);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        do_accept(64'd7, 64'd9, 7'b0110011, 3'b000, 1'b0, 1'b0);
        wait_valid(lat);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (Product !== 128'd63 || MulBusy !== 1'b1 || ProductValid !== 1'b1) bad++;
            @(posedge Clk);
            #1;
        end
        checks++;
        if (lat !== 32 || bad !== 0) begin
            errors++;
            $display("FAIL backpressure_hold: lat=%0d unstable_cycles=%0d product=%0d, want 32 0 63", lat, bad, Product);
        end
        take_product();
        checks++;
        if (MulReadyOut !== 1'b1 || MulBusy !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: ready=%b busy=%b, want 1 0", MulReadyOut, MulBusy);
        end
        do_accept(64'd11, 64'd13, 7'b0110011, 3'b000, 1'b0, 1'b0);
        wait_valid(lat);
        checks++;
        if (lat !== 32 || Product !== 128'd143) begin
            errors++;
            $display("FAIL back_to_back: lat=%0d product=%0d, want 32 143", lat, Product);
        end
        take_product();
    endtask

    task automatic test_flush();
        int lat;
        int seen;
        do_accept(64'd100, 64'd200, 7'b0110011, 3'b000, 1'b0, 1'b0);
        repeat (9) @(posedge Clk);
        @(negedge Clk);
        FlushFlag = 1'b1;
        @(posedge Clk);
        #1;
        FlushFlag = 1'b0;
        checks++;
        if (MulBusy !== 1'b0 || MulReadyOut !== 1'b1 || ProductValid !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: busy=%b ready=%b valid=%b, want 0 1 0", MulBusy, MulReadyOut, ProductValid);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk);
            #1;
            if (ProductValid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0 || Product !== 128'd143) begin
            errors++;
            $display("FAIL flush_no_valid: valid_cycles=%0d product=%0d, want 0 143", seen, Product);
        end
        @(negedge Clk);
        Mulitiplicand = 64'd4;
        Mulitiplier   = 64'd4;
        MulValidIn    = 1'b1;
        FlushFlag     = 1'b1;
        @(posedge Clk);
        #1;
        MulValidIn = 1'b0;
        FlushFlag  = 1'b0;
        checks++;
        if (MulBusy !== 1'b0 || MulReadyOut !== 1'b1) begin
            errors++;
            $display("FAIL flush_beats_accept: busy=%b ready=%b, want 0 1", MulBusy, MulReadyOut);
        end
        do_accept(64'd2, 64'd3, 7'b0110011, 3'b000, 1'b0, 1'b0);
        wait_valid(lat);
        checks++;
        if (lat !== 32 || Product !== 128'd6) begin
            errors++;
            $display("FAIL flush_recover: lat=%0d product=%0d, want 32 6", lat, Product);
        end
        take_product();
    endtask

    task automatic test_async_reset();
        int lat;
        do_accept(64'd1000, 64'd1000, 7'b0111011, 3'b010, 1'b1, 1'b1);
        repeat (10) @(posedge Clk);
        #2;
        Rst = 1'b0;
        #1;
        checks++;
        if (MulReadyOut !== 1'b1 || MulBusy !== 1'b0 || ProductValid !== 1'b0 || Product !== '0 ||
            MulOpCodeToEx !== 7'd0 || MulFunct3ToEx !== 3'd0 || MulitiplicandHighestBit !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: ready=%b busy=%b valid=%b product=%h opc=%b f3=%b, want 1 0 0 0 0 0",
                     MulReadyOut, MulBusy, ProductValid, Product, MulOpCodeToEx, MulFunct3ToEx);
        end
        @(negedge Clk);
        Rst = 1'b1;
        do_accept(64'd12345, 64'd678, 7'b0110011, 3'b000, 1'b0, 1'b0);
        wait_valid(lat);
        checks++;
        if (lat !== 32 || Product !== 128'd8369910) begin
            errors++;
            $display("FAIL async_recover: lat=%0d product=%0d, want 32 8369910", lat, Product);
        end
        take_product();
    endtask

    initial begin
        checks              = 0;
        errors              = 0;
        MulValidIn          = 1'b0;
        Mulitiplicand       = '0;
        Mulitiplier         = '0;
        MulOpCodeIn         = '0;
        MulFunct3In         = '0;
        MulitiplicandSignIn = 1'b0;
        MulitiplierSignIn   = 1'b0;
        FlushFlag           = 1'b0;
        ProductReady        = 1'b0;
        test_reset();
        test_basic();
        test_max();
        test_zero_skip();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
